mem_access_stage: RTL
=====================

Name: mem_access_stage

Overview:
- MEM stage of the pipeline; sits directly downstream of the EX/MEM pipeline register and feeds the WB stage.
- Converts the registered MEM_* controls into a req/ack data-memory transaction:
  - byte/half/word alignment;
  - store byte enables;
  - load extract with sign or zero extension.
- Stalls the upstream pipeline while a transaction is outstanding.
- Registers results into the MEM/WB boundary.

Parameters:
- ADDR_W, 32, data-memory address width (low ADDR_W bits of MEM_aluResult).

Ports:
- clk  in  1  clock, rising-edge.
- rst  in  1  synchronous active-high reset.
- MEM_PC  in  32  PC of the instruction in MEM.
- MEM_RegWrite  in  1  register write enable.
- MEM_WriteReg  in  5  destination register.
- MEM_RegSrc  in  2  writeback source select; passed through.
- MEM_MemWrite  in  1  store.
- MEM_MemRead  in  1  load.
- MEM_MemOp  in  2  access size: 00 byte, 01 half, 10 word, 11 treated as word.
- MEM_MemEXT  in  1  load extension: 1 sign, 0 zero.
- MEM_rfOut2  in  32  store data.
- MEM_aluResult  in  32  effective address / ALU result.
- dmem_req  out  1  transaction request, registered.
- dmem_we  out  1  1 = write.
- dmem_addr  out  ADDR_W  word-aligned address (low 2 bits 0).
- dmem_be  out  4  byte enables.
- dmem_wdata  out  32  lane-replicated store data.
- dmem_ack  in  1  transaction complete; rdata valid this cycle.
- dmem_rdata  in  32  read word.
- mem_stall  out  1  combinational; upstream holds EX/MEM and earlier stages while 1.
- WB_PC  out  32  registered.
- WB_RegWrite  out  1  registered.
- WB_WriteReg  out  5  registered.
- WB_RegSrc  out  2  registered.
- WB_aluResult  out  32  registered.
- WB_memData  out  32  registered, extended load data.

Behaviour:
- Reset (rst=1 at posedge):
  - state=IDLE.
  - dmem_req, dmem_we, dmem_addr, dmem_be, dmem_wdata = 0.
  - All WB_* = 0.
  - Reset mid-transaction drops dmem_req next cycle; a late ack after reset is ignored.
- Memory op: op = MEM_MemWrite | MEM_MemRead. If both are set, treat as store (MemWrite wins).
- State machine: IDLE, ACCESS.
  - IDLE, op=1:
    - mem_stall=1.
    - At posedge latch dmem_addr/be/wdata/we and set dmem_req=1; go to ACCESS.
  - IDLE, op=0:
    - mem_stall=0; no request.
  - ACCESS:
    - Hold dmem_req and all dmem_* stable until dmem_ack.
    - mem_stall = ~dmem_ack.
    - On ack: dmem_req<=0, state<=IDLE, WB registers capture.
  - dmem_ack in IDLE is ignored.
- Minimum latency: 2 cycles for a memory op (issue cycle + ack cycle); 1 cycle for non-memory instructions.
- WB register update at each posedge (when rst=0):
  - mem_stall=0: WB_* <= MEM_* pass-through; WB_memData <= extracted load data (0 for non-loads).
  - mem_stall=1: bubble — WB_RegWrite<=0; other WB_* hold.
- Store lanes, with a = MEM_aluResult[1:0]:
  - Byte: be = 4'b0001<<a; wdata = {4{rfOut2[7:0]}}.
  - Half: be = 4'b0011<<{a[1],1'b0}; wdata = {2{rfOut2[15:0]}}.
  - Word: be = 4'b1111; wdata = rfOut2.
  - Loads: be = 4'b1111, we=0.
- Load extract, using the latched address low bits:
  - Byte: dmem_rdata[8a+7:8a].
  - Half: dmem_rdata at the half selected by a[1].
  - Word: full word.
  - Extension: MemEXT=1 sign-extends to 32; MemEXT=0 zero-extends.
- Misaligned access (default build): low bits ignored for lane selection of the access size; half uses a[1] only, word uses none. No trap.

Optional Feature:
- Macro: MEM_MISALIGN_TRAP_EN
- Defined:
  - Adds outputs mem_misalign (1, registered) and WB_badAddr (32, registered); both reset to 0.
  - Misaligned op (half with a[0]=1, or word with a!=0) issues no request and does not stall.
  - At the next posedge: WB_RegWrite<=0, mem_misalign<=1 for one cycle, WB_badAddr<=MEM_aluResult.
- Undefined: ports absent; misaligned accesses handled as in Behaviour.

Test Plan:
- Reset during ACCESS (req=1, no ack), assert rst one cycle -> next cycle dmem_req=0, all WB_*=0, state IDLE; ack pulse afterwards produces no WB update.
- Word load, addr 0x100, ack on second cycle, rdata=0xDEADBEEF -> dmem_addr=0x100, be=1111, mem_stall=1,1,0 over 3 cycles, then WB_memData=0xDEADBEEF, WB_RegWrite=1.
- Byte store 0x000000A5 at addr 0x203 -> dmem_addr=0x200, be=1000, wdata=0xA5A5A5A5, we=1.
- Half load signed at addr 0x2 with rdata=0x80010000 -> WB_memData=0xFFFF8001; same with MemEXT=0 -> 0x00008001.
- Non-memory ALU instruction (RegWrite=1, WriteReg=5, aluResult=7) -> no req, mem_stall=0, next cycle WB_aluResult=7, WB_WriteReg=5.
- With MEM_MISALIGN_TRAP_EN, word load at 0x102 -> no dmem_req, mem_misalign=1 for one cycle, WB_badAddr=0x102, WB_RegWrite=0.

Source files
------------

// File: rtl/mem_access_stage.sv
// MEM pipeline stage: issues req/ack data-memory transactions (alignment, byte enables, load extension) and registers MEM/WB.
// Optional feature macro MEM_MISALIGN_TRAP_EN: misaligned half/word accesses trap instead of issuing.
//
// state  | meaning
// IDLE   | nothing outstanding; a memory op issues from here
// ACCESS | request held stable until dmem_ack
module mem_access_stage #(
  parameter int ADDR_W = 32
) (
  input  logic              clk,
  input  logic              rst,
  input  logic [31:0]       MEM_PC,
  input  logic              MEM_RegWrite,
  input  logic [4:0]        MEM_WriteReg,
  input  logic [1:0]        MEM_RegSrc,
  input  logic              MEM_MemWrite,
  input  logic              MEM_MemRead,
  input  logic [1:0]        MEM_MemOp,
  input  logic              MEM_MemEXT,
  input  logic [31:0]       MEM_rfOut2,
  input  logic [31:0]       MEM_aluResult,
  output logic              dmem_req,
  output logic              dmem_we,
  output logic [ADDR_W-1:0] dmem_addr,
  output logic [3:0]        dmem_be,
  output logic [31:0]       dmem_wdata,
  input  logic              dmem_ack,
  input  logic [31:0]       dmem_rdata,
  output logic              mem_stall,
`ifdef MEM_MISALIGN_TRAP_EN
  output logic              mem_misalign,
  output logic [31:0]       WB_badAddr,
`endif
  output logic [31:0]       WB_PC,
  output logic              WB_RegWrite,
  output logic [4:0]        WB_WriteReg,
  output logic [1:0]        WB_RegSrc,
  output logic [31:0]       WB_aluResult,
  output logic [31:0]       WB_memData
);

  typedef enum logic {IDLE, ACCESS} state_t;

  state_t      state, stateNext;
  logic        memOp, misalign, issue, complete;
  logic [1:0]  a;
  logic [3:0]  beNext;
  logic [31:0] wdataNext;
  logic [1:0]  ldLo, ldSize;
  logic        ldExt, ldRead;
  logic [7:0]  laneByte;
  logic [15:0] laneHalf;
  logic [31:0] loadData;

  assign memOp = MEM_MemWrite | MEM_MemRead;
  assign a     = MEM_aluResult[1:0];

`ifdef MEM_MISALIGN_TRAP_EN
  assign misalign = memOp && (state == IDLE) &&
                    ((MEM_MemOp == 2'b01) ? a[0] : ((MEM_MemOp != 2'b00) && (a != 2'b00)));
`else
  assign misalign = 1'b0;
`endif

  always_ff @(posedge clk) begin
    if (rst) state <= IDLE;
    else     state <= stateNext;
  end

  always_comb begin
    stateNext = state;
    mem_stall = 1'b0;
    issue     = 1'b0;
    complete  = 1'b0;
    unique case (state)
      IDLE: begin
        if (memOp && !misalign) begin
          mem_stall = 1'b1;
          issue     = 1'b1;
          stateNext = ACCESS;
        end
      end
      ACCESS: begin
        mem_stall = ~dmem_ack;
        if (dmem_ack) begin
          complete  = 1'b1;
          stateNext = IDLE;
        end
      end
      default: stateNext = IDLE;
    endcase
  end

  // Store lanes; MemOp 11 falls through to word like 10.
  always_comb begin
    beNext    = 4'b1111;
    wdataNext = MEM_rfOut2;
    unique case (MEM_MemOp)
      2'b00: begin
        beNext    = 4'b0001 << a;
        wdataNext = {4{MEM_rfOut2[7:0]}};
      end
      2'b01: begin
        beNext    = 4'b0011 << {a[1], 1'b0};
        wdataNext = {2{MEM_rfOut2[15:0]}};
      end
      default: ;
    endcase
    if (!MEM_MemWrite) beNext = 4'b1111;
  end

  always_comb begin
    laneByte = dmem_rdata[{ldLo, 3'b000} +: 8];
    laneHalf = ldLo[1] ? dmem_rdata[31:16] : dmem_rdata[15:0];
    unique case (ldSize)
      2'b00:   loadData = {{24{ldExt & laneByte[7]}}, laneByte};
      2'b01:   loadData = {{16{ldExt & laneHalf[15]}}, laneHalf};
      default: loadData = dmem_rdata;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      dmem_req   <= 1'b0;
      dmem_we    <= 1'b0;
      dmem_addr  <= '0;
      dmem_be    <= 4'b0000;
      dmem_wdata <= 32'h0;
      ldLo       <= 2'b00;
      ldSize     <= 2'b00;
      ldExt      <= 1'b0;
      ldRead     <= 1'b0;
    end else if (issue) begin
      dmem_req   <= 1'b1;
      dmem_we    <= MEM_MemWrite;
      dmem_addr  <= {MEM_aluResult[ADDR_W-1:2], 2'b00};
      dmem_be    <= beNext;
      dmem_wdata <= wdataNext;
      ldLo       <= a;
      ldSize     <= MEM_MemOp;
      ldExt      <= MEM_MemEXT;
      ldRead     <= MEM_MemRead & ~MEM_MemWrite;
    end else if (complete) begin
      dmem_req   <= 1'b0;
    end
  end

  // MEM/WB boundary: pass through when not stalled, otherwise insert a bubble.
  always_ff @(posedge clk) begin
    if (rst) begin
      WB_PC        <= 32'h0;
      WB_RegWrite  <= 1'b0;
      WB_WriteReg  <= 5'd0;
      WB_RegSrc    <= 2'b00;
      WB_aluResult <= 32'h0;
      WB_memData   <= 32'h0;
    end else if (!mem_stall) begin
      WB_PC        <= MEM_PC;
      WB_RegWrite  <= MEM_RegWrite & ~misalign;
      WB_WriteReg  <= MEM_WriteReg;
      WB_RegSrc    <= MEM_RegSrc;
      WB_aluResult <= MEM_aluResult;
      WB_memData   <= (complete && ldRead) ? loadData : 32'h0;
    end else begin
      WB_RegWrite  <= 1'b0;
    end
  end

`ifdef MEM_MISALIGN_TRAP_EN
  always_ff @(posedge clk) begin
    if (rst) begin
      mem_misalign <= 1'b0;
      WB_badAddr   <= 32'h0;
    end else begin
      mem_misalign <= misalign;
      if (misalign) WB_badAddr <= MEM_aluResult;
    end
  end
`endif

endmodule
